// File: rtl/mw_mem_ctrl.sv
// -----------------------------------------------------------------------------
// mw_mem_ctrl
//
// Stage-3 memory/writeback controller for the RV pipeline. It takes one
// instruction from the X stage and retires it on a registered writeback port.
// Loads and stores go through a variable-latency request/grant/response data
// memory port. Non-memory instructions, and memory accesses that are
// misaligned or illegal for the configured XLEN, retire on the next cycle.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/ready    X stage handshake (ready only while idle)
//   opcode, funct3    instruction decode fields
//   rd                destination register
//   alu_result        ALU output / effective address
//   store_data        rs2 value for stores
//   pc4               PC+4 for JAL/JALR
//   mem_req/addr/we/wdata  memory request (mem_we == 0 means read)
//   mem_gnt           memory accepts the request
//   mem_rvalid/rdata  load response (aligned word)
//   wb_valid          one-cycle retire pulse
//   wb_we/rd/data     register file write
//   misalign          access was misaligned and suppressed (with wb_valid)
// -----------------------------------------------------------------------------
module mw_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [4:0]          rd,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     store_data,
    input  logic [XLEN-1:0]     pc4,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_we,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                wb_valid,
    output logic                wb_we,
    output logic [4:0]          wb_rd,
    output logic [XLEN-1:0]     wb_data,
    output logic                misalign
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_D  = 3'd3;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;
    localparam logic [2:0] F3_WU = 3'd6;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t state, state_nx;

    // Byte-lane write mask; funct3[1:0] encodes the access size.
    function automatic logic [NB-1:0] store_mask(input logic [2:0] f3,
                                                 input logic [OFF_W-1:0] o);
        logic [NB-1:0] m;
        case (f3[1:0])
            2'd0:    m = NB'(1);
            2'd1:    m = NB'(3);
            2'd2:    m = NB'(15);
            default: m = '1;
        endcase
        return m << o;
    endfunction

    // The source unit is replicated across the bus, so whichever lanes the
    // mask selects already carry the right bytes.
    function automatic logic [XLEN-1:0] store_lanes(input logic [2:0] f3,
                                                    input logic [XLEN-1:0] sd);
        logic [XLEN-1:0] w;
        case (f3[1:0])
            2'd0:    w = {(NB){sd[7:0]}};
            2'd1:    w = {(NB/2){sd[15:0]}};
            2'd2:    w = {(NB/4){sd[31:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] f3,
                                                 input logic [OFF_W-1:0] o,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0] s;
        logic [XLEN-1:0] r;
        s = rdata >> {o, 3'b000};
        case (f3)
            F3_B:    r = XLEN'($signed(s[7:0]));
            F3_H:    r = XLEN'($signed(s[15:0]));
            F3_W:    r = XLEN'($signed(s[31:0]));
            F3_BU:   r = XLEN'(s[7:0]);
            F3_HU:   r = XLEN'(s[15:0]);
            F3_WU:   r = XLEN'(s[31:0]);
            default: r = s;
        endcase
        return r;
    endfunction

    // Decode of the instruction presented by the X stage.
    logic [OFF_W-1:0]  off_in;
    logic [ADDR_W-1:0] addr_al;
    logic              is_load, is_store, mem_legal, mis_in, writes_rd, use_pc4;

    always_comb begin
        off_in    = alu_result[OFF_W-1:0];
        addr_al   = ADDR_W'(alu_result) & ~ADDR_W'(NB - 1);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        writes_rd = (opcode == OP_LUI)   || (opcode == OP_AUIPC) ||
                    (opcode == OP_RTYPE) || (opcode == OP_ITYPE) ||
                    (opcode == OP_JAL)   || (opcode == OP_JALR);
        use_pc4   = (opcode == OP_JAL)   || (opcode == OP_JALR);

        // A load/store with a funct3 not legal for this XLEN behaves like an
        // unknown opcode: no access, no register write.
        case (funct3)
            F3_B, F3_H, F3_W: mem_legal = is_load || is_store;
            F3_D:             mem_legal = (XLEN == 64) && (is_load || is_store);
            F3_BU, F3_HU:     mem_legal = is_load;
            F3_WU:            mem_legal = (XLEN == 64) && is_load;
            default:          mem_legal = 1'b0;
        endcase

        case (funct3[1:0])
            2'd1:    mis_in = off_in[0];
            2'd2:    mis_in = |off_in[1:0];
            2'd3:    mis_in = |off_in;
            default: mis_in = 1'b0;
        endcase
    end

    // Fields of the accepted instruction needed after the IDLE cycle.
    logic              capture;
    logic              is_store_q;
    logic [2:0]        f3_q;
    logic [4:0]        rd_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   alu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            is_store_q <= 1'b0;
            f3_q       <= '0;
            rd_q       <= '0;
            off_q      <= '0;
            alu_q      <= '0;
        end else if (capture) begin
            is_store_q <= is_store;
            f3_q       <= funct3;
            rd_q       <= rd;
            off_q      <= off_in;
            alu_q      <= alu_result;
        end
    end

    // Next-state and next-value logic for all registered outputs.
    logic              mem_req_d, wb_valid_d, wb_we_d, misalign_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [NB-1:0]     mem_we_d;
    logic [XLEN-1:0]   mem_wdata_d, wb_data_d;
    logic [4:0]        wb_rd_d;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // can leave it unassigned and infer a latch.
        state_nx    = state;
        capture     = 1'b0;
        mem_req_d   = mem_req;
        mem_addr_d  = mem_addr;
        mem_we_d    = mem_we;
        mem_wdata_d = mem_wdata;
        wb_valid_d  = 1'b0;
        wb_we_d     = wb_we;
        wb_rd_d     = wb_rd;
        wb_data_d   = wb_data;
        misalign_d  = misalign;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    capture = 1'b1;
                    if (mem_legal && !mis_in) begin
                        state_nx    = REQ;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = addr_al;
                        mem_we_d    = is_store ? store_mask(funct3, off_in) : '0;
                        mem_wdata_d = is_store ? store_lanes(funct3, store_data) : '0;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_we_d     = writes_rd && (rd != 5'd0);
                        wb_rd_d     = rd;
                        wb_data_d   = use_pc4 ? pc4 : alu_result;
                        misalign_d  = mem_legal && mis_in;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d   = 1'b0;
                    mem_addr_d  = '0;
                    mem_we_d    = '0;
                    mem_wdata_d = '0;
                    if (is_store_q) begin
                        state_nx   = IDLE;
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        wb_rd_d    = rd_q;
                        wb_data_d  = alu_q;
                        misalign_d = 1'b0;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_nx   = IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = (rd_q != 5'd0);
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_ext(f3_q, off_q, mem_rdata);
                    misalign_d = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_we    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            misalign  <= 1'b0;
        end else begin
            state     <= state_nx;
            mem_req   <= mem_req_d;
            mem_addr  <= mem_addr_d;
            mem_we    <= mem_we_d;
            mem_wdata <= mem_wdata_d;
            wb_valid  <= wb_valid_d;
            wb_we     <= wb_we_d;
            wb_rd     <= wb_rd_d;
            wb_data   <= wb_data_d;
            misalign  <= misalign_d;
        end
    end

    assign in_ready = (state == IDLE);

endmodule

// File: doc/mw_mem_ctrl.md
# mw_mem_ctrl

Parametrised stage-3 memory/writeback controller for the RV pipeline. It absorbs the combinational MW decode (write mask, read enable, writeback select, register write enable) and extends it to a variable-latency data-memory port with a request/grant/response handshake. It also adds address-offset byte-lane alignment, load sign/zero extension, misalignment detection and a registered writeback output. It sits between the X stage result registers and the register file write port.

## Interface
Parameters:
- XLEN, 32: datapath width; legal values 32 or 64. 64 enables LD/SD/LWU.
- ADDR_W, 32: memory address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  X stage presents an instruction.
- in_ready  out  1  block can accept; high only in IDLE.
- opcode  in  7  instruction opcode.
- funct3  in  3  instruction funct3.
- rd  in  5  destination register.
- alu_result  in  XLEN  ALU output; doubles as effective address for LOAD/STORE.
- store_data  in  XLEN  rs2 value for stores.
- pc4  in  XLEN  PC+4 for JAL/JALR.
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_W  address aligned down to XLEN/8 bytes.
- mem_we  out  XLEN/8  byte write mask; zero means read.
- mem_wdata  out  XLEN  store data shifted to byte lanes.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  load data valid.
- mem_rdata  in  XLEN  load data, aligned word.
- wb_valid  out  1  one-cycle pulse: one instruction retires.
- wb_we  out  1  register write enable.
- wb_rd  out  5  register index.
- wb_data  out  XLEN  writeback value.
- misalign  out  1  qualified by wb_valid: access was misaligned and was suppressed.

## Operation
- States: IDLE, REQ, WAIT.
- IDLE, in_valid=1: capture opcode, funct3, rd, alu_result, store_data and pc4.
  - Aligned LOAD or STORE: go to REQ.
  - Anything else: retire next cycle and stay in IDLE.
- REQ: hold mem_req=1 with mem_addr, mem_we and mem_wdata stable until mem_gnt.
  - STORE granted: retire and go to IDLE.
  - LOAD granted: go to WAIT.
- WAIT: on mem_rvalid, retire the load and go to IDLE.
- mem_rvalid outside WAIT is ignored.
- Store masks use offset o = addr mod (XLEN/8):
  - SB: 1<<o
  - SH: 3<<o
  - SW: 0xF<<o
  - SD: all ones
  - Other funct3: treated as an unknown opcode.
- Store data: replicated source byte, half or word shifted to the lanes selected by o.
- Load extraction: shift mem_rdata right by 8·o, then extend.
  - LB, LH, LW: sign-extend.
  - LBU, LHU, LWU: zero-extend.
- Misaligned accesses:
  - Half at odd o; word with o mod 4 ≠ 0; double with o ≠ 0.
  - No memory access is made.
  - Retires next cycle with misalign=1 and wb_we=0.
- Writeback select:
  - LUI, AUIPC, ARI_RTYPE, ARI_ITYPE: alu_result.
  - JAL, JALR: pc4.
  - LOAD: extracted data.
  - BRANCH, STORE, unknown opcode: wb_we=0, wb_data=alu_result.
- wb_we is forced to 0 when rd=0.

## Timing
- Reset values: state IDLE; in_ready=1; mem_req=0; mem_we=0; mem_addr=0; mem_wdata=0; wb_valid=0; wb_we=0; wb_rd=0; wb_data=0; misalign=0.
- wb_* and misalign are registered. wb_valid is high for exactly one cycle per accepted instruction.
- Non-memory op: accepted at edge T, wb_valid high in cycle T+1. Back-to-back acceptance gives one retire per cycle.
- Store: REQ in cycle T+1. Grant in cycle G gives wb_valid in G+1.
- Load: grant in cycle G, WAIT from G+1; rvalid in cycle R≥G+1 gives wb_valid in R+1.
  - Minimum load latency: accept T, wb_valid T+3.
- in_ready=0 throughout REQ and WAIT. in_valid there is ignored and must be held by the X stage.
- mem_req and payload change only on entering or leaving REQ.
- rst_n asserted mid-transaction:
  - Returns immediately to IDLE and drops mem_req the same instant.
  - A later stale mem_rvalid is ignored.
  - No wb_valid is generated for the aborted instruction.

## Test plan
- Reset: rst_n low mid-cycle → all outputs at reset values immediately; in_ready=1.
- ADDI (ARI_ITYPE) rd=5, alu_result=0x1234 → one cycle later wb_valid=1, wb_we=1, wb_rd=5, wb_data=0x1234. Same with rd=0 → wb_we=0.
- SB, addr 0x1003, store_data 0xAB → mem_we=0b1000, mem_wdata[31:24]=0xAB, mem_addr=0x1000. mem_gnt held low 3 cycles → request and payload stable. After grant → wb_valid with wb_we=0.
- LH, addr 0x2002, mem_rdata 0x8001_xxxx, rvalid 2 cycles after grant → wb_data=0xFFFF8001. LHU with the same inputs → 0x00008001.
- LW at addr 0x3002 → mem_req never asserts; next cycle wb_valid=1, misalign=1, wb_we=0.
- Load in WAIT, rst_n pulsed, then mem_rvalid → no wb_valid. A following JAL rd=1 retires with wb_data=pc4.
